// File: rtl/core_l1d_resp.sv
// L1D request responder: single-port word memory with byte lanes, fixed wait-state
// latency, registered zero-extended load data and a misalignment/illegal-size error flag.
module core_l1d_resp #(
    parameter int unsigned MEM_WORDS_LOG2 = 10,
    parameter int unsigned WAIT_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        l1d_req_val,
    input  logic        l1d_req_cop,
    input  logic [2:0]  l1d_req_size,
    input  logic [31:0] l1d_req_addr,
    input  logic [31:0] l1d_req_wdata,
    output logic        l1d_req_ack,
    output logic        l1d_resp_val,
    output logic [31:0] l1d_resp_data,
    output logic        l1d_resp_err
);

    localparam int unsigned AW        = MEM_WORDS_LOG2 + 2;
    localparam int unsigned CW        = 4;
    localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            lat_cop;
    logic [2:0]      lat_size;
    logic [AW-1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [MEM_WORDS];

    logic            accept;
    logic            src_cop;
    logic [2:0]      src_size;
    logic [AW-1:0]   src_addr;
    logic            src_err;
    logic            commit;
    logic [3:0]      lat_be;
    logic [31:0]     lat_wrep;
    logic [31:0]     fwd_word;
    logic            resp_val_nxt;
    logic [31:0]     resp_data_nxt;
    logic            resp_err_nxt;
    logic            unused_addr;

    function automatic logic req_err(input logic [2:0] size, input logic [1:0] a);
        return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a != 2'd0);
    endfunction

    function automatic logic [3:0] req_be(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] req_wrep(input logic [2:0] size, input logic [31:0] w);
        case (size)
            3'd0:    return {4{w[7:0]}};
            3'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] size,
                                                 input logic [1:0] a);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        case (size)
            3'd0:    return {24'd0, sh[7:0]};
            3'd1:    return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    assign unused_addr = ^l1d_req_addr[31:AW];
    assign l1d_req_ack = (state == IDLE) || (state == RESP);
    assign accept      = l1d_req_val && l1d_req_ack;

    // Next state and wait counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (state == RESP) state_nxt = IDLE;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request feeding the response: the incoming one when it goes straight to RESP
    always_comb begin
        src_cop  = accept ? l1d_req_cop  : lat_cop;
        src_size = accept ? l1d_req_size : lat_size;
        src_addr = accept ? l1d_req_addr[AW-1:0] : lat_addr;
        src_err  = req_err(src_size, src_addr[1:0]);
        commit   = (state == RESP) && lat_cop && !req_err(lat_size, lat_addr[1:0]);
        lat_be   = req_be(lat_size, lat_addr[1:0]);
        lat_wrep = req_wrep(lat_size, lat_wdata);
    end

    // Forward a write committing on the same edge so read-after-write sees new data
    always_comb begin
        fwd_word = mem[src_addr[AW-1:2]];
        if (commit && lat_addr[AW-1:2] == src_addr[AW-1:2]) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) fwd_word[8*i +: 8] = lat_wrep[8*i +: 8];
            end
        end
    end

    always_comb begin
        resp_val_nxt  = (state_nxt == RESP);
        resp_err_nxt  = resp_val_nxt && src_err;
        resp_data_nxt = '0;
        if (resp_val_nxt && !src_cop && !src_err)
            resp_data_nxt = load_extract(fwd_word, src_size, src_addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_cop       <= 1'b0;
            lat_size      <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            l1d_resp_val  <= 1'b0;
            l1d_resp_data <= '0;
            l1d_resp_err  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            l1d_resp_val  <= resp_val_nxt;
            l1d_resp_data <= resp_data_nxt;
            l1d_resp_err  <= resp_err_nxt;
            if (accept) begin
                lat_cop   <= l1d_req_cop;
                lat_size  <= l1d_req_size;
                lat_addr  <= l1d_req_addr[AW-1:0];
                lat_wdata <= l1d_req_wdata;
            end
        end
    end

    // Store commit at the end of RESP; array intentionally has no reset
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[lat_addr[AW-1:2]][8*i +: 8] <= lat_wrep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_core_l1d_resp.sv
// Self-checking bench for core_l1d_resp: one instance with WAIT_CYCLES=1, one with 0,
// checked against a byte-addressed reference memory.
module tb_core_l1d_resp;

    logic        clk;
    logic        rst;
    logic        val   [2];
    logic        cop   [2];
    logic [2:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        rv    [2];
    logic [31:0] rd    [2];
    logic        re    [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mb [2][4096];

    core_l1d_resp #(.MEM_WORDS_LOG2(10), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .l1d_req_val(val[0]), .l1d_req_cop(cop[0]), .l1d_req_size(size[0]),
        .l1d_req_addr(addr[0]), .l1d_req_wdata(wdata[0]), .l1d_req_ack(ack[0]),
        .l1d_resp_val(rv[0]), .l1d_resp_data(rd[0]), .l1d_resp_err(re[0])
    );

    core_l1d_resp #(.MEM_WORDS_LOG2(10), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .l1d_req_val(val[1]), .l1d_req_cop(cop[1]), .l1d_req_size(size[1]),
        .l1d_req_addr(addr[1]), .l1d_req_wdata(wdata[1]), .l1d_req_ack(ack[1]),
        .l1d_resp_val(rv[1]), .l1d_resp_data(rd[1]), .l1d_resp_err(re[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: little-endian byte memory of 4 KiB, address wraps modulo 4096
    function automatic logic m_err(input logic [2:0] s, input logic [31:0] a);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] m_resp(input int d, input logic c, input logic [2:0] s,
                                           input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (c || m_err(s, a)) return 32'd0;
        for (int k = 0; k < (1 << s); k++)
            r = r | (32'(mb[d][int'((a + 32'(k)) & 32'hFFF)]) << (8 * k));
        return r;
    endfunction

    function automatic void m_write(input int d, input logic [2:0] s, input logic [31:0] a,
                                    input logic [31:0] w);
        if (m_err(s, a)) return;
        for (int k = 0; k < (1 << s); k++)
            mb[d][int'((a + 32'(k)) & 32'hFFF)] = w[8*k +: 8];
    endfunction

    // Issue one request on instance d and wait (bounded) for its response
    task automatic xact(input int d, input logic c, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] w, output logic [31:0] odata, output logic oerr,
                        output int lat);
        int g;
        @(negedge clk);
        cop[d] = c; size[d] = s; addr[d] = a; wdata[d] = w; val[d] = 1'b1;
        g = 0;
        while (!ack[d] && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        lat = -1; odata = 32'hx; oerr = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) val[d] = 1'b0;
            if (rv[d]) begin
                lat = n; odata = rd[d]; oerr = re[d];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            val[d] = 1'b1; cop[d] = 1'b0; size[d] = 3'd2; addr[d] = 32'h40; wdata[d] = 32'h0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({rv[d], rd[d], re[d]} !== 34'd0) begin
                    failures++;
                    $display("FAIL reset_outputs dut%0d cyc%0d: val=%b data=%h err=%b required all 0",
                             d, i, rv[d], rd[d], re[d]);
                end
            end
        end
        rst = 1'b0; val[0] = 1'b0; val[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack[d] !== 1'b1 || rv[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release dut%0d: ack=%b val=%b required ack=1 val=0",
                         d, ack[d], rv[d]);
            end
        end
    endtask

    // Fill the low 256 bytes of both instances so later reads are defined
    task automatic test_init();
        logic [31:0] od; logic oe; int lat; int bad;
        for (int d = 0; d < 2; d++) begin
            bad = 0;
            for (int w = 0; w < 64; w++) begin
                logic [31:0] v;
                v = $urandom;
                xact(d, 1'b1, 3'd2, 32'(w * 4), v, od, oe, lat);
                m_write(d, 3'd2, 32'(w * 4), v);
                if (lat != 2 - d || oe !== 1'b0 || od !== 32'd0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL init_writes dut%0d: bad_responses=%0d required 0", d, bad);
            end
        end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] od; logic oe; int lat;
        xact(0, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, od, oe, lat);
        m_write(0, 3'd2, 32'h40, 32'hDEADBEEF);
        checks++;
        if (lat != 2 || oe !== 1'b0 || od !== 32'd0) begin
            failures++;
            $display("FAIL word_write: lat=%0d err=%b data=%h required lat=2 err=0 data=0",
                     lat, oe, od);
        end
        xact(0, 1'b0, 3'd2, 32'h40, 32'h0, od, oe, lat);
        checks++;
        if (lat != 2 || oe !== 1'b0 || od !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_read: lat=%0d err=%b data=%h required lat=2 err=0 data=deadbeef",
                     lat, oe, od);
        end
    endtask

    task automatic test_subword();
        logic [31:0] od; logic oe; int lat;
        xact(0, 1'b1, 3'd0, 32'h41, 32'hFFFFFF5A, od, oe, lat);
        m_write(0, 3'd0, 32'h41, 32'hFFFFFF5A);
        xact(0, 1'b0, 3'd2, 32'h40, 32'h0, od, oe, lat);
        checks++;
        if (od !== 32'hDEAD5AEF || oe !== 1'b0) begin
            failures++;
            $display("FAIL sb_then_lw: data=%h err=%b required dead5aef err=0", od, oe);
        end
        xact(0, 1'b0, 3'd1, 32'h42, 32'h0, od, oe, lat);
        checks++;
        if (od !== 32'h0000DEAD || oe !== 1'b0) begin
            failures++;
            $display("FAIL lh_0x42: data=%h err=%b required 0000dead err=0", od, oe);
        end
        xact(0, 1'b0, 3'd0, 32'h43, 32'h0, od, oe, lat);
        checks++;
        if (od !== 32'h000000DE || oe !== 1'b0) begin
            failures++;
            $display("FAIL lb_0x43: data=%h err=%b required 000000de err=0", od, oe);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] od; logic oe; int lat;
        xact(0, 1'b1, 3'd2, 32'h44, 32'hCAFEF00D, od, oe, lat);
        m_write(0, 3'd2, 32'h44, 32'hCAFEF00D);
        xact(0, 1'b0, 3'd1, 32'h41, 32'h0, od, oe, lat);
        checks++;
        if (lat != 2 || oe !== 1'b1 || od !== 32'd0) begin
            failures++;
            $display("FAIL lh_misaligned: lat=%0d err=%b data=%h required lat=2 err=1 data=0",
                     lat, oe, od);
        end
        xact(0, 1'b1, 3'd2, 32'h46, 32'h11111111, od, oe, lat);
        checks++;
        if (lat != 2 || oe !== 1'b1 || od !== 32'd0) begin
            failures++;
            $display("FAIL sw_misaligned: lat=%0d err=%b data=%h required lat=2 err=1 data=0",
                     lat, oe, od);
        end
        xact(0, 1'b1, 3'd3, 32'h44, 32'h11111111, od, oe, lat);
        checks++;
        if (lat != 2 || oe !== 1'b1 || od !== 32'd0) begin
            failures++;
            $display("FAIL size3_write: lat=%0d err=%b data=%h required lat=2 err=1 data=0",
                     lat, oe, od);
        end
        xact(0, 1'b0, 3'd2, 32'h44, 32'h0, od, oe, lat);
        checks++;
        if (od !== 32'hCAFEF00D || oe !== 1'b0) begin
            failures++;
            $display("FAIL misalign_no_write: data=%h err=%b required cafef00d err=0", od, oe);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cop[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h80; wdata[1] = 32'h12345678; val[1] = 1'b1;
        checks++;
        if (ack[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack0: ack=%b required 1", ack[1]);
        end
        @(negedge clk);
        checks++;
        if (ack[1] !== 1'b1 || rv[1] !== 1'b1 || re[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_write_resp: ack=%b val=%b err=%b required 1 1 0", ack[1], rv[1], re[1]);
        end
        cop[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (rv[1] !== 1'b1 || rd[1] !== 32'h12345678 || re[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_read_resp: val=%b data=%h err=%b required 1 12345678 0",
                     rv[1], rd[1], re[1]);
        end
        val[1] = 1'b0;
        m_write(1, 3'd2, 32'h80, 32'h12345678);
        @(negedge clk);
        checks++;
        if (rv[1] !== 1'b0 || rd[1] !== 32'd0 || re[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: val=%b data=%h err=%b required all 0", rv[1], rd[1], re[1]);
        end
    endtask

    task automatic test_abort_alias();
        logic [31:0] od; logic oe; int lat; int seen; logic [31:0] prior; logic [31:0] v;
        prior = m_resp(0, 1'b0, 3'd2, 32'h48);
        @(negedge clk);
        cop[0] = 1'b1; size[0] = 3'd2; addr[0] = 32'h48; wdata[0] = ~prior; val[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1; val[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rv[0] !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_resp: resp_cycles=%0d required 0", seen);
        end
        xact(0, 1'b0, 3'd2, 32'h48, 32'h0, od, oe, lat);
        checks++;
        if (od !== prior || oe !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_write: data=%h err=%b required %h err=0", od, oe, prior);
        end
        v = $urandom;
        xact(0, 1'b1, 3'd2, 32'h1000, v, od, oe, lat);
        m_write(0, 3'd2, 32'h1000, v);
        xact(0, 1'b0, 3'd2, 32'h0, 32'h0, od, oe, lat);
        checks++;
        if (od !== v || od !== m_resp(0, 1'b0, 3'd2, 32'h0)) begin
            failures++;
            $display("FAIL alias_0x1000: data=%h required %h", od, v);
        end
    endtask

    task automatic test_random();
        logic [31:0] od; logic oe; int lat;
        logic c; logic [2:0] s; logic [31:0] a; logic [31:0] w; logic [31:0] ed; logic ee;
        int r;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 80; i++) begin
                c = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 9));
                s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
                a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
                w = $urandom;
                ed = m_resp(d, c, s, a);
                ee = m_err(s, a);
                xact(d, c, s, a, w, od, oe, lat);
                if (c) m_write(d, s, a, w);
                checks++;
                if (od !== ed || oe !== ee || lat != 2 - d) begin
                    failures++;
                    $display("FAIL rand dut%0d #%0d cop=%b size=%0d addr=%h: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                             d, i, c, s, a, od, oe, lat, ed, ee, 2 - d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_roundtrip();
        test_subword();
        test_misalign();
        test_back_to_back();
        test_abort_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
